// File: rtl/move_tx.sv
// move_tx: UART (8N1) transmitter for 13-bit move words.
// A move is held in a one-entry buffer and sent as a frame: byte0 = {3'b101, move[12:8]},
// then byte1 = move[7:0].
// Optional feature: define MOVE_TX_CHECKSUM_EN to append byte2 = byte0 ^ byte1 to every frame.
module move_tx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_valid,
  input  logic [12:0] moveData,
  output logic        move_ready,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned MOVE_W = 13;
  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef MOVE_TX_CHECKSUM_EN
  localparam int unsigned NUM_BYTES = 3;
`else
  localparam int unsigned NUM_BYTES = 2;
`endif
  localparam int unsigned FRAME_W = 8 * NUM_BYTES;
  localparam int unsigned BYTE_W  = 2;
  localparam logic [2:0]  HDR     = 3'b101;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_clk_cnt;
  logic [2:0]          r_bit_cnt;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [FRAME_W-1:0]  r_shift;
  logic [MOVE_W-1:0]   r_buf_data;
  logic                r_buf_full;
  logic                r_ready;
  logic                r_tx;
  logic                r_busy;

  logic                w_accept;
  logic                w_leave_idle;
  logic                w_bit_end;
  logic                w_last_byte;
  logic                w_frame_end;
  logic                w_full_next;
  logic                w_active_next;
  logic [7:0]          w_byte0;
  logic [7:0]          w_byte1;
  logic [FRAME_W-1:0]  w_frame;

  assign move_ready = r_ready;
  assign tx         = r_tx;
  assign busy       = r_busy;

  assign w_accept      = move_valid & r_ready;
  assign w_leave_idle  = (r_state == IDLE) & r_buf_full;
  assign w_bit_end     = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_byte   = (r_byte_cnt == BYTE_W'(NUM_BYTES - 1));
  assign w_frame_end   = (r_state == STOP) & w_bit_end & w_last_byte;
  assign w_full_next   = w_accept | (r_buf_full & ~w_leave_idle);
  assign w_active_next = (r_state == IDLE) ? r_buf_full : ~w_frame_end;

  // Frame bytes built from the buffered move, byte0 in the low bits so it shifts out first
  assign w_byte0 = {HDR, r_buf_data[12:8]};
  assign w_byte1 = r_buf_data[7:0];
`ifdef MOVE_TX_CHECKSUM_EN
  assign w_frame = {w_byte0 ^ w_byte1, w_byte1, w_byte0};
`else
  assign w_frame = {w_byte1, w_byte0};
`endif

  // One-entry move buffer, ready flag and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf_data <= moveData;
      end
      r_buf_full <= w_full_next;
      r_ready    <= ~w_full_next;
      r_busy     <= w_active_next | w_full_next;
    end
  end

  // Transmit FSM: bit timing, serial shifter and registered tx line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx       <= 1'b1;
          r_clk_cnt  <= '0;
          r_bit_cnt  <= '0;
          r_byte_cnt <= '0;
          if (r_buf_full) begin
            r_shift <= w_frame;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_state   <= DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              r_tx      <= 1'b1;
              r_state   <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (w_last_byte) begin
              r_byte_cnt <= '0;
              r_tx       <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
              r_tx       <= 1'b0;
              r_state    <= START;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/move_tx.md
MOVE_TX -- requirements
Module: move_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 217, giving clk cycles per serial bit (25 MHz / 115200 baud); legal range 2..4095.
REQ-002 The module SHALL have port clk, input, 1 bit: the 25 MHz system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port move_valid, input, 1 bit: moveData holds a move to send.
REQ-005 The module SHALL have port moveData, input, 13 bits: the move word from the user state machine.
REQ-006 The module SHALL have port move_ready, output, 1 bit: high when the module can accept a move.
REQ-007 The module SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-008 The module SHALL have port busy, output, 1 bit: high while a frame is in flight or a move is buffered.

Function
REQ-009 A move SHALL be accepted on any rising clk edge where move_valid and move_ready are both 1.
REQ-010 The module SHALL hold one accepted move in a one-entry buffer; move_ready SHALL be 1 exactly when that buffer is empty.
REQ-011 A move SHALL be accepted while a frame is transmitting, but only when the buffer is empty.
REQ-012 Each move SHALL produce one frame: byte0 = {3'b101, moveData[12:8]}, then byte1 = moveData[7:0].
REQ-013 Each byte SHALL be sent as 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT clk cycles; there SHALL be no idle gap between bytes of a frame.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP. IDLE goes to START when the buffer is full. START goes to DATA after one bit time. DATA goes to STOP after the 8th bit. STOP goes to START if another byte of the frame remains, otherwise to IDLE.
REQ-016 The buffer SHALL be emptied on the cycle the FSM leaves IDLE. Its move SHALL be loaded into the frame shifter at that point, so move_ready rises on the next cycle.
REQ-017 The start bit SHALL appear on tx on the cycle after the IDLE-to-START transition; tx SHALL be registered.
REQ-018 After one frame's final stop bit, a buffered move SHALL begin with IDLE for exactly one cycle, then START.
REQ-019 On an accept edge, the value of moveData SHALL be captured; later changes to moveData SHALL NOT affect the frame.
REQ-020 move_valid while move_ready is 0 SHALL be ignored, with no drop flag and no overwrite.
REQ-021 busy SHALL be 1 whenever the FSM is not in IDLE or the buffer is full.
REQ-022 The bit counter and byte counter SHALL be sized to the parameter and wrap only by state transition, never by overflow.

Reset
REQ-023 While reset is 0, outputs SHALL be tx=1, move_ready=0, busy=0, with the FSM in IDLE, the buffer empty and all counters 0.
REQ-024 move_ready SHALL become 1 on the first rising clk edge after reset deasserts.
REQ-025 Reset asserted mid-frame SHALL force tx=1 immediately, without waiting for a clock, and SHALL discard both the frame in flight and the buffered move.

Configuration
REQ-026 With macro MOVE_TX_CHECKSUM_EN defined, each frame SHALL carry a third byte, byte2 = byte0 XOR byte1, in the same 8N1 format.
REQ-027 Without MOVE_TX_CHECKSUM_EN, each frame SHALL be exactly two bytes; no checksum logic SHALL be synthesised, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset with CLKS_PER_BIT=4 -> tx=1, busy=0, and move_ready=1 one edge after reset deasserts.
REQ-029 CLKS_PER_BIT=4, accept moveData=13'h1A5C, no checksum -> tx sends 0 then bits of 8'hBA LSB first then 1, immediately followed by 0 then bits of 8'h5C then 1. The total is 80 cycles, after which busy=0.
REQ-030 Same move with MOVE_TX_CHECKSUM_EN defined -> a third byte 8'hE6 follows, for 120 cycles total.
REQ-031 Back-to-back case: accept 13'h0001, then 13'h1FFF during frame 1; hold move_valid for a third move -> the third move is refused (move_ready=0) until frame 2 starts, and frames 1 and 2 are sent correctly with exactly one idle cycle between them.
REQ-032 Assert reset during bit 3 of byte0 -> tx=1 asynchronously; after release no residual frame is sent and the next accepted move transmits cleanly.
REQ-033 Change moveData on the cycle after acceptance -> the transmitted bytes match the captured value.
